// File: rtl/display_pkg.sv
// Shared constants and types for the eight-digit multiplexed display scanner.
package display_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Digit positions, rightmost (centesimas) first
    localparam logic [2:0] IDX_CC = 3'd0;
    localparam logic [2:0] IDX_DC = 3'd1;
    localparam logic [2:0] IDX_US = 3'd2;
    localparam logic [2:0] IDX_DS = 3'd3;
    localparam logic [2:0] IDX_UM = 3'd4;
    localparam logic [2:0] IDX_DM = 3'd5;
    localparam logic [2:0] IDX_UH = 3'd6;
    localparam logic [2:0] IDX_DH = 3'd7;

    // Digits whose decimal point is lit: s.cc, m.ss, h.mm
    localparam logic [7:0] DP_MASK = 8'b01010100;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup, {g,f,e,d,c,b,a} active-low
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_8dig.sv
// Eight-digit common-anode display scanner.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BLANK | one clk with all anodes off before the next digit is driven
// ST_SHOW  | digit idx driven until the next scan tick
//
// Digits are snapshotted once per frame (at the 7->0 wrap) so a frame never
// mixes old and new counter values; lap simply suppresses that snapshot.
module display_scan_8dig
    import display_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stay,
    input  logic       lap,
    input  logic       lzb_en,
    input  logic       blink_en,
    input  logic [3:0] centesimas,
    input  logic [3:0] decimas,
    input  logic [3:0] unidadesSegundo,
    input  logic [2:0] decenasSegundo,
    input  logic [3:0] unidadesMinuto,
    input  logic [3:0] decenasMinuto,
    input  logic [3:0] unidadesHora,
    input  logic [1:0] decenasHora,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    scan_state_t   state, state_next;
    logic [2:0]    idx, idx_next;
    logic          frame_wrap;
    logic [3:0]    shadow   [8];
    logic [3:0]    digit_in [8];
    logic [6:0]    seg_dec;
    logic          lzb_blank;
    logic          blink_gate;

    assign digit_in[IDX_CC] = centesimas;
    assign digit_in[IDX_DC] = decimas;
    assign digit_in[IDX_US] = unidadesSegundo;
    assign digit_in[IDX_DS] = {1'b0, decenasSegundo};
    assign digit_in[IDX_UM] = unidadesMinuto;
    assign digit_in[IDX_DM] = decenasMinuto;
    assign digit_in[IDX_UH] = unidadesHora;
    assign digit_in[IDX_DH] = {2'b00, decenasHora};

    assign tick = (pre_cnt == SCAN_LAST);

    // Scan prescaler: free-running 0..SCAN_DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Blink phase: toggles every BLINK_DIV clocks, starts in the visible phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // FSM state and digit index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_BLANK;
            idx   <= IDX_CC;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic: one blank clk, then show until the next tick
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_BLANK: state_next = ST_SHOW;
            ST_SHOW: begin
                if (tick) begin
                    state_next = ST_BLANK;
                    idx_next   = idx + 3'd1;
                end
            end
            default: state_next = ST_BLANK;
        endcase
    end

    assign frame_wrap = (state == ST_SHOW) && tick && (idx == IDX_DH);

    // Frame-coherent snapshot, held while lap is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (frame_wrap && !lap) begin
            for (int i = 0; i < 8; i++) shadow[i] <= digit_in[i];
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (shadow[idx]),
        .seg (seg_dec)
    );

    assign lzb_blank  = (idx == IDX_DH) && lzb_en && (shadow[IDX_DH] == 4'd0);
    assign blink_gate = !stay && blink_en && !blink_on;

    // Registered pin drivers; seg/dp keep tracking even when anodes are gated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 8'hFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_dec;
            dp  <= ~DP_MASK[idx];
            if ((state == ST_SHOW) && !lzb_blank && !blink_gate) begin
                an <= ~(8'd1 << idx);
            end else begin
                an <= 8'hFF;
            end
        end
    end

endmodule
